// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard unit: forwarding, load-use/branch stalls and flushes, mul/div busy FSM
// Optional macro HAZARD_FWD_EN enables operand forwarding; undefined, RAW hazards from E/M stall instead.
module hazard_ctrl #(
    parameter int MD_LAT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       LoadE,
    input  logic       PCSrcE,
    input  logic       MdStartE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM,
    output logic       MdBusy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] LP_CNT_LOAD = 4'(MD_LAT - 1);

    state_t     r_state;
    logic [3:0] r_cnt;

    logic w_busy;
    logic w_lw_stall;
    logic w_d_stall;

    assign w_busy     = (r_state == ST_BUSY);
    assign w_lw_stall = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

`ifdef HAZARD_FWD_EN
    logic w_unused;

    assign w_unused  = RegWriteE;
    assign ForwardAE = (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E)) ? 2'b10 :
                       (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) ? 2'b01 : 2'b00;
    assign ForwardBE = (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E)) ? 2'b10 :
                       (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) ? 2'b01 : 2'b00;
    assign w_d_stall = w_lw_stall;
`else
    logic w_unused;
    logic w_raw_e;
    logic w_raw_m;

    // Writeback hazards resolve through the write-first register file.
    assign w_unused  = ^{Rs1E, Rs2E, RdW, RegWriteW};
    assign w_raw_e   = RegWriteE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign w_raw_m   = RegWriteM && (RdM != 5'd0) && ((RdM == Rs1D) || (RdM == Rs2D));
    assign ForwardAE = 2'b00;
    assign ForwardBE = 2'b00;
    assign w_d_stall = w_lw_stall || w_raw_e || w_raw_m;
`endif

    // BUSY freezes the front end and overrides branch and load-use handling.
    assign StallF = w_busy || (!PCSrcE && w_d_stall);
    assign StallD = w_busy || (!PCSrcE && w_d_stall);
    assign StallE = w_busy;
    assign FlushD = !w_busy && PCSrcE;
    assign FlushE = !w_busy && (PCSrcE || w_d_stall);
    assign FlushM = w_busy;
    assign MdBusy = w_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (MdStartE) begin
                        r_state <= ST_BUSY;
                        r_cnt   <= LP_CNT_LOAD;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed scoreboard bench for hazard_ctrl (MD_LAT=4 and MD_LAT=1 instances)
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteE, RegWriteM, RegWriteW, LoadE, PCSrcE, MdStartE;

    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy;

    logic [1:0] l1_fa, l1_fb;
    logic       l1_sf, l1_sd, l1_se, l1_fd, l1_fe, l1_fm, l1_busy;

    int checks   = 0;
    int failures = 0;

    logic [10:0] q_exp[$];
    string       q_tag[$];
    logic        q_l1[$];

    always #5 clk = ~clk;

    hazard_ctrl #(.MD_LAT(4)) u_dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .LoadE(LoadE), .PCSrcE(PCSrcE), .MdStartE(MdStartE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .MdBusy(MdBusy)
    );

    hazard_ctrl #(.MD_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .LoadE(LoadE), .PCSrcE(PCSrcE), .MdStartE(MdStartE),
        .ForwardAE(l1_fa), .ForwardBE(l1_fb),
        .StallF(l1_sf), .StallD(l1_sd), .StallE(l1_se),
        .FlushD(l1_fd), .FlushE(l1_fe), .FlushM(l1_fm), .MdBusy(l1_busy)
    );

    function automatic logic [10:0] mk(input logic [1:0] fa, input logic [1:0] fb,
                                       input logic sf, input logic sd, input logic se,
                                       input logic fd, input logic fe, input logic fm,
                                       input logic busy);
        return {fa, fb, sf, sd, se, fd, fe, fm, busy};
    endfunction

    localparam logic [10:0] E_ZERO = 11'd0;
    logic [10:0] e_lw, e_busy, e_br;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        LoadE = 0; PCSrcE = 0; MdStartE = 0;
    endtask

    task automatic push(input string tag, input logic [10:0] e);
        q_exp.push_back(e);
        q_tag.push_back(tag);
    endtask

    task automatic cmp();
        logic [10:0] obs;
        logic [10:0] e;
        string       tag;
        @(negedge clk);
        e   = q_exp.pop_front();
        tag = q_tag.pop_front();
        obs = {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy};
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b (fa,fb,sf,sd,se,fd,fe,fm,busy)", tag, obs, e);
        end
    endtask

    task automatic cmp_l1(input string tag);
        logic e;
        e = q_l1.pop_front();
        checks++;
        assert (l1_busy === e) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, l1_busy, e);
        end
    endtask

    initial begin
        e_lw   = mk(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0);
        e_busy = mk(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 1);
        e_br   = mk(2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0);

        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        push("reset_outputs", E_ZERO);
        cmp();

        // forwarding: M beats W, then W, then x0 never forwards
        tick();
        RegWriteM = 1; RdM = 5; Rs1E = 5; RegWriteW = 1; RdW = 5;
`ifdef HAZARD_FWD_EN
        push("fwd_m_priority", mk(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0));
`else
        push("fwd_m_priority", E_ZERO);
`endif
        cmp();
        RegWriteM = 0; Rs2E = 5;
`ifdef HAZARD_FWD_EN
        push("fwd_w", mk(2'b01, 2'b01, 0, 0, 0, 0, 0, 0, 0));
`else
        push("fwd_w", E_ZERO);
`endif
        cmp();
        RdW = 0; Rs1E = 0; Rs2E = 0;
        push("fwd_x0", E_ZERO);
        cmp();

        // load-use bubble, then the x0 destination boundary
        tick();
        clear_inputs();
        LoadE = 1; RdE = 7; Rs2D = 7;
        push("lw_stall", e_lw);
        cmp();
        tick();
        LoadE = 0;
        push("lw_bubble_done", E_ZERO);
        cmp();
        LoadE = 1; RdE = 0; Rs2D = 0;
        push("lw_rd_x0", E_ZERO);
        cmp();

        // branch wins over load-use
        LoadE = 1; RdE = 7; Rs2D = 7; PCSrcE = 1;
        push("branch_over_lw", e_br);
        cmp();

        // multi-cycle op: 4 BUSY cycles, DONE ignoring MdStartE, then IDLE
        tick();
        clear_inputs();
        MdStartE = 1;
        push("md_issue_idle", E_ZERO);
        cmp();
        tick();
        MdStartE = 0;
        for (int i = 0; i < 4; i++) push($sformatf("md_busy_%0d", i), e_busy);
        push("md_done", E_ZERO);
        push("md_idle_after_done", E_ZERO);
        push("md_idle_hold", E_ZERO);
        q_l1.push_back(1'b1);
        q_l1.push_back(1'b0);
        for (int c = 0; c < 7; c++) begin
            MdStartE = (c == 4);
            cmp();
            if (c < 2) cmp_l1($sformatf("lat1_busy_cycle_%0d", c));
            tick();
        end

        // same branch + load-use stimulus inside BUSY is ignored
        clear_inputs();
        MdStartE = 1;
        push("md2_issue", E_ZERO);
        cmp();
        tick();
        clear_inputs();
        LoadE = 1; RdE = 7; Rs2D = 7; PCSrcE = 1;
        push("busy_ignores_branch_lw", e_busy);
        cmp();
        tick();
        push("busy_cycle2_pre_reset", e_busy);
        reset = 1;
        clear_inputs();
        cmp();
        tick();
        reset = 0;
        push("reset_aborts_busy", E_ZERO);
        cmp();
        tick();
        push("idle_after_abort", E_ZERO);
        cmp();

        // reset has priority over MdStartE at the same edge
        reset = 1; MdStartE = 1;
        tick();
        reset = 0; MdStartE = 0;
        push("reset_over_start", E_ZERO);
        cmp();

        // RAW hazards on Decode sources from M and E; W is resolved
        tick();
        RegWriteM = 1; RdM = 3; Rs1D = 3;
`ifdef HAZARD_FWD_EN
        push("raw_m_decode", E_ZERO);
`else
        push("raw_m_decode", e_lw);
`endif
        cmp();
        clear_inputs();
        RegWriteE = 1; RdE = 4; Rs2D = 4;
`ifdef HAZARD_FWD_EN
        push("raw_e_decode", E_ZERO);
`else
        push("raw_e_decode", e_lw);
`endif
        cmp();
        clear_inputs();
        RegWriteW = 1; RdW = 3; Rs1D = 3;
        push("raw_w_resolved", E_ZERO);
        cmp();
        clear_inputs();
        RegWriteM = 1; RdM = 3; Rs1D = 3; PCSrcE = 1;
        push("branch_over_raw", e_br);
        cmp();
        clear_inputs();
        RegWriteM = 1; RdM = 0; Rs1D = 0;
        push("raw_m_x0", E_ZERO);
        cmp();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MD_LAT, default 4, the multi-cycle (mul/div) execute latency in cycles, legal range 1..16.
REQ-002 SHALL have port clk  input  1  pipeline clock, rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports Rs1D, Rs2D  input  5  source registers of the instruction in Decode.
REQ-005 SHALL have ports Rs1E, Rs2E, RdE  input  5  source and destination registers in Execute.
REQ-006 SHALL have ports RdM, RdW  input  5  destination registers in Memory and Writeback.
REQ-007 SHALL have ports RegWriteE, RegWriteM, RegWriteW  input  1  destination-write enables per stage.
REQ-008 SHALL have port LoadE  input  1  the instruction in Execute is a load.
REQ-009 SHALL have port PCSrcE  input  1  branch or jump taken, resolved in Execute.
REQ-010 SHALL have port MdStartE  input  1  a multi-cycle op is in Execute.
REQ-011 SHALL have ports ForwardAE, ForwardBE  output  2  ALU operand select: 00 register file, 01 Writeback result, 10 Memory ALU result.
REQ-012 SHALL have ports StallF, StallD, StallE  output  1  hold the PC, IF/ID and ID/EX registers.
REQ-013 SHALL have ports FlushD, FlushE, FlushM  output  1  clear the IF/ID, ID/EX and EX/MEM registers.
REQ-014 SHALL have port MdBusy  output  1  multi-cycle FSM in BUSY.

Function
REQ-015 SHALL drive ForwardAE = 10 when RegWriteM, RdM != 0 and RdM == Rs1E; else 01 when RegWriteW, RdW != 0 and RdW == Rs1E; else 00. ForwardBE follows the same rule on Rs2E, and M has priority over W.
REQ-016 SHALL compute lwStall = LoadE & (RdE != 0) & (RdE == Rs1D | RdE == Rs2D).
REQ-017 On lwStall, SHALL assert StallF, StallD and FlushE combinationally in the same cycle, inserting exactly one bubble.
REQ-018 On PCSrcE, SHALL assert FlushD and FlushE combinationally in the same cycle.
REQ-019 SHALL implement FSM states IDLE, BUSY and DONE with a 4-bit down-counter.
REQ-020 In IDLE, MdStartE = 1 SHALL move the FSM to BUSY at the next edge and load the counter with MD_LAT-1.
REQ-021 In BUSY, counter == 0 SHALL move the FSM to DONE; otherwise the counter decrements by 1. BUSY therefore lasts exactly MD_LAT cycles.
REQ-022 DONE SHALL last one cycle, always return to IDLE, and ignore MdStartE, because the issuing op is still in Execute.
REQ-023 In BUSY, SHALL assert StallF, StallD, StallE, FlushM and MdBusy.
REQ-024 In DONE, SHALL assert no stall outputs, so the op advances to Memory.
REQ-025 Priority SHALL be BUSY > PCSrcE > lwStall. While BUSY, FlushD and FlushE SHALL be 0 and lwStall and PCSrcE SHALL be ignored.
REQ-026 When PCSrcE and lwStall coincide, SHALL assert FlushD and FlushE with StallF = StallD = 0.
REQ-027 Outputs SHALL be combinational from the FSM state and the inputs. The only registers SHALL be the FSM state and the counter.

Reset
REQ-028 When reset is high at a rising edge, the FSM SHALL go to IDLE and the counter SHALL clear to 0.
REQ-029 After reset with all inputs 0, every output SHALL be 0.
REQ-030 Reset asserted in BUSY SHALL abort the op: at the next edge the FSM is in IDLE and MdBusy = 0.
REQ-031 reset SHALL take priority over MdStartE at the same edge.

Configuration
REQ-032 Macro HAZARD_FWD_EN defined: forwarding SHALL operate per REQ-015.
REQ-033 Macro HAZARD_FWD_EN undefined:
- ForwardAE and ForwardBE SHALL be constant 00.
- Any RAW match (nonzero Rd equal to Rs1D or Rs2D, with RegWrite set) from stage E or M SHALL assert StallF, StallD and FlushE under the lwStall priority.
- W matches SHALL be treated as resolved, since the register file is write-first.

Verification
REQ-034 RegWriteM=1, RdM=5, Rs1E=5, and RegWriteW=1, RdW=5 -> ForwardAE=10; then clear RegWriteM -> ForwardAE=01; then RdW=0, Rs1E=0 -> 00.
REQ-035 LoadE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle; RdE=0 -> no stall.
REQ-036 MD_LAT=4, MdStartE pulse in IDLE -> MdBusy and StallE high for exactly 4 cycles, one DONE cycle with no stalls, then IDLE.
REQ-037 PCSrcE=1 together with lwStall -> FlushD=FlushE=1 and StallF=0; the same stimulus during BUSY -> FlushD=FlushE=0.
REQ-038 Reset on the 2nd BUSY cycle -> next cycle IDLE, all outputs 0; with MD_LAT=1 -> exactly 1 BUSY cycle.
REQ-039 Without HAZARD_FWD_EN, RegWriteM=1, RdM=3, Rs1D=3 -> one stall cycle and ForwardAE=00.
